// File: rtl/fb_pkg.sv
// Shared constants, state encoding and brush helper for the frame buffer write scheduler.
// FB_BRUSH_3X3_EN selects the 3x3 brush; when it is undefined a single-cell brush is built.
package fb_pkg;

  localparam int FB_WIDTH  = 80;
  localparam int FB_HEIGHT = 60;
  localparam int X_W       = 7;
  localparam int Y_W       = 6;
  localparam int FB_CELLS  = FB_WIDTH * FB_HEIGHT;

`ifdef FB_BRUSH_3X3_EN
  localparam int BRUSH_R = 1;
`else
  localparam int BRUSH_R = 0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    CLEAR = 2'd2
  } fb_state_t;

  typedef logic signed [2:0] brush_off_t;

  localparam brush_off_t BRUSH_MIN = brush_off_t'(-BRUSH_R);
  localparam brush_off_t BRUSH_MAX = brush_off_t'(BRUSH_R);

  typedef struct packed {
    logic           en;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           data;
  } fb_wr_t;

  // One bit of headroom lets negative and past-the-edge targets be spotted by the sign bit.
  function automatic fb_wr_t brush_cell(input logic [X_W-1:0] cx, input logic [Y_W-1:0] cy,
                                        input brush_off_t dx, input brush_off_t dy,
                                        input logic colour);
    logic signed [X_W:0] tx;
    logic signed [Y_W:0] ty;
    fb_wr_t              w;
    tx     = $signed({1'b0, cx}) + $signed({{(X_W-2){dx[2]}}, dx});
    ty     = $signed({1'b0, cy}) + $signed({{(Y_W-2){dy[2]}}, dy});
    w.en   = !tx[X_W] && (tx[X_W-1:0] < X_W'(FB_WIDTH)) &&
             !ty[Y_W] && (ty[Y_W-1:0] < Y_W'(FB_HEIGHT));
    w.x    = tx[X_W-1:0];
    w.y    = ty[Y_W-1:0];
    w.data = colour;
    return w;
  endfunction

endpackage

// File: rtl/framebuffer_write_scheduler_if.sv
// Stroke request, clear request and frame buffer write bus of the scheduler.
// The slave modport is the scheduler; the master modport is the requester/buffer side.
interface framebuffer_write_scheduler_if
  import fb_pkg::*;
();

  logic           draw_valid;
  logic           draw_ready;
  logic [X_W-1:0] draw_x;
  logic [Y_W-1:0] draw_y;
  logic           draw_colour;
  logic           clear_req;
  logic           clear_busy;
  logic           wr_en;
  logic [X_W-1:0] wr_x;
  logic [Y_W-1:0] wr_y;
  logic           wr_data;

  modport master (
    output draw_valid, draw_x, draw_y, draw_colour, clear_req,
    input  draw_ready, clear_busy, wr_en, wr_x, wr_y, wr_data
  );

  modport slave (
    input  draw_valid, draw_x, draw_y, draw_colour, clear_req,
    output draw_ready, clear_busy, wr_en, wr_x, wr_y, wr_data
  );

endinterface

// File: rtl/fb_clear_scanner.sv
// Row-major cell counter for the whole-screen clear: (0,0), (1,0) .. (79,59).
// Holds the cell currently being written and offers the following cell and a last-cell flag.
module fb_clear_scanner
  import fb_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           advance,
  output logic [X_W-1:0] nxt_x,
  output logic [Y_W-1:0] nxt_y,
  output logic           last
);

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           row_end;

  assign row_end = (x == X_W'(FB_WIDTH - 1));
  assign last    = row_end && (y == Y_W'(FB_HEIGHT - 1));
  assign nxt_x   = row_end ? '0 : x + X_W'(1);
  assign nxt_y   = row_end ? y + Y_W'(1) : y;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (start) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      x <= nxt_x;
      y <= nxt_y;
    end
  end

endmodule

// File: rtl/framebuffer_write_scheduler.sv
// Sole writer of the 80x60 frame buffer: arbitrates brush strokes against a whole-screen clear.
// Brush size follows FB_BRUSH_3X3_EN (3x3 when defined, single cell otherwise) via fb_pkg.
//
// state | meaning
// IDLE  | ready for a stroke unless a clear is pending
// DRAW  | one brush offset per cycle, out-of-screen cells suppressed
// CLEAR | row-major scan writing 0, one cell per cycle
module framebuffer_write_scheduler
  import fb_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  framebuffer_write_scheduler_if.slave bus
);

  fb_state_t      state, state_nxt;
  logic           clear_pending, pending_nxt;
  logic [X_W-1:0] sx;
  logic [Y_W-1:0] sy;
  logic           scol;
  brush_off_t     dx_c, dy_c, dx_step, dy_step;
  fb_wr_t         wr_q, wr_d;
  logic           draw_ready, accept, stroke_last;
  logic           scan_start, scan_advance, scan_last;
  logic [X_W-1:0] scan_nxt_x;
  logic [Y_W-1:0] scan_nxt_y;

  // A clear arriving alongside a stroke must win, so the raw pulse also closes the handshake.
  assign draw_ready   = (state == IDLE) && !clear_pending && !bus.clear_req;
  assign accept       = bus.draw_valid && draw_ready;
  assign stroke_last  = (dx_c == BRUSH_MAX) && (dy_c == BRUSH_MAX);
  assign scan_start   = (state != CLEAR) && (state_nxt == CLEAR);
  assign scan_advance = (state == CLEAR) && !scan_last;

  fb_clear_scanner u_scan (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (scan_start),
    .advance (scan_advance),
    .nxt_x   (scan_nxt_x),
    .nxt_y   (scan_nxt_y),
    .last    (scan_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      clear_pending <= 1'b0;
    end else begin
      state         <= state_nxt;
      clear_pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = clear_pending | bus.clear_req;
    case (state)
      IDLE: begin
        if (clear_pending)  state_nxt = CLEAR;
        else if (accept)    state_nxt = DRAW;
      end
      DRAW: begin
        if (stroke_last)    state_nxt = clear_pending ? CLEAR : IDLE;
      end
      CLEAR: begin
        pending_nxt = !scan_last;
        if (scan_last)      state_nxt = IDLE;
      end
      default:              state_nxt = IDLE;
    endcase
  end

  // Dy is the outer loop, dx the inner one.
  always_comb begin
    dx_step = dx_c + brush_off_t'(1);
    dy_step = dy_c;
    if (dx_c == BRUSH_MAX) begin
      dx_step = BRUSH_MIN;
      dy_step = dy_c + brush_off_t'(1);
    end
  end

  // Computes the write for the coming cycle so every write output leaves a flop.
  always_comb begin
    wr_d = '0;
    case (state_nxt)
      DRAW: begin
        if (state == IDLE)
          wr_d = brush_cell(bus.draw_x, bus.draw_y, BRUSH_MIN, BRUSH_MIN, bus.draw_colour);
        else
          wr_d = brush_cell(sx, sy, dx_step, dy_step, scol);
      end
      CLEAR: begin
        wr_d.en = 1'b1;
        if (state == CLEAR) begin
          wr_d.x = scan_nxt_x;
          wr_d.y = scan_nxt_y;
        end
      end
      default: wr_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      sx   <= '0;
      sy   <= '0;
      scol <= 1'b0;
      dx_c <= '0;
      dy_c <= '0;
    end else begin
      wr_q <= wr_d;
      if (accept) begin
        sx   <= bus.draw_x;
        sy   <= bus.draw_y;
        scol <= bus.draw_colour;
      end
      if (state_nxt == DRAW) begin
        if (state == IDLE) begin
          dx_c <= BRUSH_MIN;
          dy_c <= BRUSH_MIN;
        end else begin
          dx_c <= dx_step;
          dy_c <= dy_step;
        end
      end
    end
  end

  assign bus.draw_ready = draw_ready;
  assign bus.clear_busy = clear_pending;
  assign bus.wr_en      = wr_q.en;
  assign bus.wr_x       = wr_q.x;
  assign bus.wr_y       = wr_q.y;
  assign bus.wr_data    = wr_q.data;

endmodule

// File: tb/tb_framebuffer_write_scheduler.sv
// Scoreboard bench for framebuffer_write_scheduler: expected writes are queued from a cell-list model,
// a negedge monitor pops and compares every wr_en cycle.
module tb_framebuffer_write_scheduler;

  localparam int W = 80;
  localparam int H = 60;
`ifdef FB_BRUSH_3X3_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif
  localparam int N = (2*R+1)*(2*R+1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  framebuffer_write_scheduler_if bus();

  framebuffer_write_scheduler dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          wr_seen = 0;
  logic [13:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_stroke(input int cx, input int cy, input logic col);
    for (int dy = -R; dy <= R; dy++)
      for (int dx = -R; dx <= R; dx++) begin
        int tx;
        int ty;
        tx = cx + dx;
        ty = cy + dy;
        if (tx >= 0 && tx < W && ty >= 0 && ty < H)
          exp_q.push_back({7'(tx), 6'(ty), col});
      end
  endtask

  task automatic push_clear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({7'(x), 6'(y), 1'b0});
  endtask

  always @(negedge clk) begin : monitor
    logic [13:0] e;
    if (reset_n && bus.wr_en) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_queue_size", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("write_cell_xyd", int'({bus.wr_x, bus.wr_y, bus.wr_data}), int'(e));
      end
    end
  end

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.draw_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("ready_seen", int'(ok), 1);
  endtask

  task automatic do_stroke(input int cx, input int cy, input logic col, input int gap);
    bit ok;
    int busy;
    wait_ready(10000, ok);
    if (!ok) return;
    bus.draw_x      = 7'(cx);
    bus.draw_y      = 6'(cy);
    bus.draw_colour = col;
    bus.draw_valid  = 1'b1;
    push_stroke(cx, cy, col);
    @(posedge clk);
    #1 bus.draw_valid = 1'b0;
    busy = 0;
    for (int i = 0; i < N + 5; i++) begin
      @(negedge clk);
      if (bus.draw_ready) break;
      busy++;
    end
    check("stroke_cycles", busy, N);
    check("stroke_drain", exp_q.size(), 0);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  first, last, cnt, ready_hi, base, j, exp_first;
    bit  ok, accepted, done;

    bus.draw_valid  = 1'b0;
    bus.draw_x      = '0;
    bus.draw_y      = '0;
    bus.draw_colour = 1'b0;
    bus.clear_req   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_wr_en", int'(bus.wr_en), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", int'(bus.draw_ready), 1);
    check("post_reset_wr_en", int'(bus.wr_en), 0);
    check("post_reset_busy", int'(bus.clear_busy), 0);

    // Directed strokes, including corners, off-screen centre and a single interior cell
    do_stroke(10, 20, 1'b1, 0);
    do_stroke(0, 0, 1'b1, 1);
    do_stroke(79, 59, 1'b0, 2);
    do_stroke(5, 5, 1'b1, 0);
    do_stroke(127, 63, 1'b1, 0);
    do_stroke(80, 30, 1'b1, 0);

    for (int k = 0; k < 25; k++)
      do_stroke(int'($urandom_range(0, 127)), int'($urandom_range(0, 63)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));

    // Full clear with a second request mid-scan that must be ignored
    wait_ready(100, ok);
    push_clear();
    bus.clear_req = 1'b1;
    @(posedge clk);
    #1 bus.clear_req = 1'b0;
    first = -1; last = -1; cnt = 0; ready_hi = 0; done = 1'b0;
    for (int i = 1; i < 6000; i++) begin
      @(negedge clk);
      if (i == 1) check("clear_busy_rise", int'(bus.clear_busy), 1);
      if (i == 300) bus.clear_req = 1'b1;
      if (i == 301) bus.clear_req = 1'b0;
      if (!bus.clear_busy) begin
        done = 1'b1;
        break;
      end
      if (bus.draw_ready) ready_hi++;
      if (bus.wr_en) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("clear_done", int'(done), 1);
    check("clear_first_cycle", first, 2);
    check("clear_span", last - first + 1, W*H);
    check("clear_write_count", cnt, W*H);
    check("clear_ready_low", ready_hi, 0);
    check("clear_end_ready", int'(bus.draw_ready), 1);
    check("clear_drain", exp_q.size(), 0);

    // Clear requested on stroke cycle 4 (or the last cycle of a shorter stroke)
    j = (N >= 4) ? 4 : N;
    exp_first = (j < N) ? N + 1 : N + 2;
    wait_ready(100, ok);
    bus.draw_x = 7'd40; bus.draw_y = 6'd30; bus.draw_colour = 1'b1; bus.draw_valid = 1'b1;
    push_stroke(40, 30, 1'b1);
    push_clear();
    @(posedge clk);
    #1 bus.draw_valid = 1'b0;
    first = -1; ready_hi = 0; done = 1'b0;
    for (int i = 1; i < 6000; i++) begin
      @(negedge clk);
      bus.clear_req = (i == j);
      if (i > j && !bus.clear_busy) begin
        done = 1'b1;
        break;
      end
      if (bus.draw_ready) ready_hi++;
      if (first < 0 && bus.wr_en && !bus.wr_data) first = i;
    end
    bus.clear_req = 1'b0;
    check("mid_stroke_clear_done", int'(done), 1);
    check("mid_stroke_scan_start", first, exp_first);
    check("mid_stroke_ready_low", ready_hi, 0);
    check("mid_stroke_drain", exp_q.size(), 0);

    // Stroke and clear in the same IDLE cycle: the clear goes first
    wait_ready(100, ok);
    bus.draw_x = 7'd3; bus.draw_y = 6'd4; bus.draw_colour = 1'b1;
    bus.draw_valid = 1'b1; bus.clear_req = 1'b1;
    push_clear();
    push_stroke(3, 4, 1'b1);
    base = wr_seen;
    @(posedge clk);
    #1 bus.clear_req = 1'b0;
    accepted = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (bus.draw_ready) begin
        check("same_cycle_clear_writes_first", wr_seen - base, W*H);
        @(posedge clk);
        #1 bus.draw_valid = 1'b0;
        accepted = 1'b1;
        break;
      end
    end
    bus.draw_valid = 1'b0;
    check("same_cycle_stroke_accepted", int'(accepted), 1);
    repeat (N + 3) @(negedge clk);
    check("same_cycle_drain", exp_q.size(), 0);

    // Reset partway through a clear
    wait_ready(100, ok);
    push_clear();
    base = wr_seen;
    bus.clear_req = 1'b1;
    @(posedge clk);
    #1 bus.clear_req = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (wr_seen - base >= 1000) break;
    end
    check("reset_point_reached", int'(wr_seen - base >= 1000), 1);
    #1 reset_n = 1'b0;
    #1;
    check("abort_wr_en", int'(bus.wr_en), 0);
    check("abort_busy", int'(bus.clear_busy), 0);
    check("abort_wr_x", int'(bus.wr_x), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    base = wr_seen;
    repeat (30) @(negedge clk);
    check("no_resume_writes", wr_seen - base, 0);
    check("no_resume_busy", int'(bus.clear_busy), 0);
    check("no_resume_ready", int'(bus.draw_ready), 1);

    do_stroke(5, 5, 1'b1, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
